// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the pipelined core. It takes the execute-stage result
// and runs loads and stores against data memory using a req/ack handshake.
// While an access is outstanding it holds the upstream stage with stall. The
// write-back result (data, destination, write enable) is registered, and
// wb_valid marks it with a one-cycle pulse.
//
// Ports
//   clock, reset      : single clock domain; synchronous active-high reset
//   valid_in          : an operation from execute is present
//   alu_result        : effective address, or the pass-through ALU result
//   store_data        : store operand
//   mem_read/mem_write: load / store (store wins if both are set)
//   mem_size          : 00 byte, 01 half, 1x word
//   mem_unsigned      : zero-extend loads when set, sign-extend otherwise
//   reg_write/write_reg: destination register write enable and index
//   stall             : upstream must hold its inputs while this is high
//   dmem_*            : data memory request channel (word address, byte lanes)
//   wb_*              : registered write-back result; wb_valid is a pulse
//   addr_error        : pulse for a misaligned access, which is never issued
//   bus_error         : pulse when an access times out without an ack
//
// Optional feature: define MEM_ACK_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles with no ack. Without it the stage waits indefinitely
// and bus_error stays 0.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_write,
  output logic        addr_error,
  output logic        bus_error
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_reg, state_next;

  // Operation latched when the access is accepted. The bus outputs are driven
  // straight from these registers, so they stay stable for the whole access.
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic        we_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [1:0]  lane_reg;
  logic        reg_write_reg;
  logic [4:0]  write_reg_reg;

  logic        wb_valid_reg;
  logic [31:0] wb_data_reg;
  logic [4:0]  wb_reg_reg;
  logic        wb_write_reg;
  logic        addr_error_reg;
  logic        bus_error_reg;

  logic        is_mem;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_data;
  logic        timeout_hit;

  // ---------------------------------------------------------------------------
  // Request decode (IDLE side)
  // ---------------------------------------------------------------------------
  assign is_mem     = mem_read | mem_write;
  assign misaligned = ((mem_size == 2'b01) && alu_result[0]) ||
                      (mem_size[1] && (alu_result[1:0] != 2'b00));

  // Byte lane enables: byte selects its own lane, half selects the lane pair
  // chosen by addr[1], word enables all lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_be
      always_comb begin
        be_calc[gi] = 1'b1;
        if (mem_size == 2'b00)
          be_calc[gi] = (alu_result[1:0] == 2'(gi));
        else if (mem_size == 2'b01)
          be_calc[gi] = (alu_result[1] == 1'(gi / 2));
      end
    end
  endgenerate

  // Store data is replicated across lanes so memory can pick it up from the
  // enabled lane without any shifting.
  always_comb begin
    wdata_calc = store_data;
    if (mem_size == 2'b00)
      wdata_calc = {4{store_data[7:0]}};
    else if (mem_size == 2'b01)
      wdata_calc = {2{store_data[15:0]}};
  end

  // ---------------------------------------------------------------------------
  // Load data extraction (ACCESS side), using the latched lane and size
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte   = dmem_rdata[{lane_reg, 3'b000} +: 8];
    ld_half   = dmem_rdata[{lane_reg[1], 4'b0000} +: 16];
    load_data = dmem_rdata;
    if (size_reg == 2'b00)
      load_data = {{24{~unsigned_reg & ld_byte[7]}}, ld_byte};
    else if (size_reg == 2'b01)
      load_data = {{16{~unsigned_reg & ld_half[15]}}, ld_half};
  end

  // ---------------------------------------------------------------------------
  // Optional ack timeout
  // ---------------------------------------------------------------------------
`ifdef MEM_ACK_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] tmo_cnt_reg;

  // The counter is zero in the first ACCESS cycle, so the limit is reached in
  // the TIMEOUT_CYCLES-th cycle of the access. An ack in that cycle still
  // completes normally because the FSM checks dmem_ack first.
  assign timeout_hit = (state_reg == ACCESS) &&
                       (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || state_next != ACCESS || state_reg != ACCESS)
      tmo_cnt_reg <= '0;
    else
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and stall
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Stall in the accept cycle so upstream holds its inputs until the
        // access completes.
        if (valid_in && is_mem && !misaligned) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall = ~(dmem_ack | timeout_hit);
        if (dmem_ack || timeout_hit)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, latched operation and registered results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      be_reg         <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      lane_reg       <= '0;
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      wb_valid_reg   <= 1'b0;
      wb_data_reg    <= '0;
      wb_reg_reg     <= '0;
      wb_write_reg   <= 1'b0;
      addr_error_reg <= 1'b0;
      bus_error_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wb_valid_reg   <= 1'b0;
      addr_error_reg <= 1'b0;
      bus_error_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              wb_valid_reg <= 1'b1;
              wb_data_reg  <= alu_result;
              wb_reg_reg   <= write_reg;
              wb_write_reg <= reg_write;
            end else if (misaligned) begin
              wb_valid_reg   <= 1'b1;
              wb_data_reg    <= alu_result;
              wb_reg_reg     <= write_reg;
              wb_write_reg   <= 1'b0;
              addr_error_reg <= 1'b1;
            end else begin
              addr_reg      <= {alu_result[31:2], 2'b00};
              be_reg        <= be_calc;
              we_reg        <= mem_write;
              wdata_reg     <= wdata_calc;
              size_reg      <= mem_size;
              unsigned_reg  <= mem_unsigned;
              lane_reg      <= alu_result[1:0];
              reg_write_reg <= reg_write;
              write_reg_reg <= write_reg;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            wb_valid_reg <= 1'b1;
            // A store has nothing to write back; keep its address on wb_data.
            wb_data_reg  <= we_reg ? addr_reg : load_data;
            wb_reg_reg   <= write_reg_reg;
            wb_write_reg <= we_reg ? 1'b0 : reg_write_reg;
          end else if (timeout_hit) begin
            wb_valid_reg  <= 1'b1;
            wb_reg_reg    <= write_reg_reg;
            wb_write_reg  <= 1'b0;
            bus_error_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req   = (state_reg == ACCESS);
  assign dmem_we    = we_reg & dmem_req;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;

  assign wb_valid   = wb_valid_reg;
  assign wb_data    = wb_data_reg;
  assign wb_reg     = wb_reg_reg;
  assign wb_write   = wb_write_reg;
  assign addr_error = addr_error_reg;
  assign bus_error  = bus_error_reg;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage in its default build (no ack timeout).
// Directed cases from the test plan are followed by randomized operations.
// Expected bus fields and write-back data come from a behavioural reference
// model computed with plain arithmetic on address, size and read data.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clock;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_write;
  logic        addr_error;
  logic        bus_error;

  int n_cmp;
  int n_bad;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_in     (valid_in),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_reg       (wb_reg),
    .wb_write     (wb_write),
    .addr_error   (addr_error),
    .bus_error    (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_misaligned(input int size, input logic [31:0] a);
    if (size == 1) return (a % 2) != 0;
    if (size >= 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input int size, input logic [31:0] a);
    if (size == 0) return 4'(1 << (a % 4));
    if (size == 1) return ((a / 2) % 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] sd);
    if (size == 0) return (sd % 256) * 32'h0101_0101;
    if (size == 1) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (size == 0) begin
      v = (rd >> (8 * (a % 4))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rd >> (16 * ((a / 2) % 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Presents one operation, services the memory side with `delay` idle cycles
  // before the ack, and checks bus fields and the write-back result.
  task automatic do_op(input string nm, input bit rd, input bit wr, input int size,
                       input bit uns, input bit rw, input logic [4:0] wreg,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rdata, input int delay);
    bit is_mem;
    bit mis;
    is_mem = rd || wr;
    mis    = is_mem && m_misaligned(size, addr);
    @(negedge clock);
    valid_in     = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = 2'(size);
    mem_unsigned = uns;
    reg_write    = rw;
    write_reg    = wreg;
    alu_result   = addr;
    store_data   = sd;
    dmem_ack     = 1'b0;
    #1 check({nm, ".stall_accept"}, 32'(stall), 32'(is_mem && !mis));
    @(negedge clock);
    if (!is_mem || mis) begin
      valid_in = 1'b0;
      check({nm, ".wb_valid"}, 32'(wb_valid), 32'd1);
      check({nm, ".wb_write"}, 32'(wb_write), 32'(!is_mem && rw));
      check({nm, ".addr_error"}, 32'(addr_error), 32'(mis));
      check({nm, ".no_req"}, 32'(dmem_req), 32'd0);
      if (!is_mem) begin
        check({nm, ".wb_data"}, wb_data, addr);
        check({nm, ".wb_reg"}, 32'(wb_reg), 32'(wreg));
      end
    end else begin
      check({nm, ".req"}, 32'(dmem_req), 32'd1);
      check({nm, ".we"}, 32'(dmem_we), 32'(wr));
      check({nm, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
      check({nm, ".be"}, 32'(dmem_be), 32'(m_be(size, addr)));
      if (wr) check({nm, ".wdata"}, dmem_wdata, m_wdata(size, sd));
      for (int k = 0; k < delay; k++) begin
        check({nm, ".wait_stall"}, 32'(stall), 32'd1);
        check({nm, ".wait_wbv"}, 32'(wb_valid), 32'd0);
        @(negedge clock);
      end
      check({nm, ".req_held"}, 32'(dmem_req), 32'd1);
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      #1 check({nm, ".stall_ack"}, 32'(stall), 32'd0);
      @(negedge clock);
      dmem_ack = 1'b0;
      valid_in = 1'b0;
      check({nm, ".wb_valid"}, 32'(wb_valid), 32'd1);
      check({nm, ".wb_write"}, 32'(wb_write), 32'(!wr && rw));
      check({nm, ".req_done"}, 32'(dmem_req), 32'd0);
      check({nm, ".addr_error"}, 32'(addr_error), 32'd0);
      if (!wr) begin
        check({nm, ".wb_data"}, wb_data, m_load(size, uns, addr, rdata));
        check({nm, ".wb_reg"}, 32'(wb_reg), 32'(wreg));
      end
    end
    check({nm, ".bus_error"}, 32'(bus_error), 32'd0);
    @(negedge clock);
    check({nm, ".wbv_pulse"}, 32'(wb_valid), 32'd0);
    check({nm, ".err_pulse"}, 32'(addr_error), 32'd0);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    valid_in     = 1'b0;
    alu_result   = '0;
    store_data   = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = '0;
    mem_unsigned = 1'b0;
    reg_write    = 1'b0;
    write_reg    = '0;
    dmem_rdata   = '0;
    dmem_ack     = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst.req", 32'(dmem_req), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.dmem_be", 32'(dmem_be), 32'd0);
    check("rst.dmem_addr", dmem_addr, 32'd0);

    // Directed test plan items
    do_op("alu", 0, 0, 2, 0, 1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0);
    do_op("lb_s", 1, 0, 0, 0, 1, 5'd7, 32'h0000_0103, 32'h0, 32'h8012_3456, 3);
    do_op("sh", 0, 1, 1, 0, 1, 5'd9, 32'h0000_0102, 32'hAABB_CCDD, 32'h0, 1);
    do_op("lw_mis", 1, 0, 2, 0, 1, 5'd3, 32'h0000_0101, 32'h0, 32'h0, 0);
    do_op("lh_mis", 1, 0, 1, 1, 1, 5'd4, 32'h0000_0203, 32'h0, 32'h0, 0);
    do_op("lbu", 1, 0, 0, 1, 1, 5'd6, 32'h0000_0042, 32'h0, 32'h11F2_3344, 0);
    do_op("lh_s", 1, 0, 1, 0, 1, 5'd8, 32'h0000_0300, 32'h0, 32'h0000_9ABC, 2);
    do_op("both_st", 1, 1, 0, 0, 1, 5'd2, 32'h0000_0401, 32'h1234_56A5, 32'h0, 0);

    // Ack while idle must be ignored
    @(negedge clock);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1 check("idle_ack.stall", 32'(stall), 32'd0);
    @(negedge clock);
    dmem_ack = 1'b0;
    check("idle_ack.wb_valid", 32'(wb_valid), 32'd0);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      do_op($sformatf("rnd%0d", i), op[0], op[1], int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
            32'($urandom), 32'($urandom), 32'($urandom), int'($urandom_range(0, 4)));
    end

    // Reset during an access drops it
    @(negedge clock);
    valid_in   = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    mem_size   = 2'b10;
    reg_write  = 1'b1;
    write_reg  = 5'd12;
    alu_result = 32'h0000_0200;
    store_data = 32'h5555_AAAA;
    @(negedge clock);
    check("rst_acc.req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    valid_in = 1'b0;
    mem_read = 1'b0;
    check("rst_acc.req", 32'(dmem_req), 32'd0);
    check("rst_acc.ctl", 32'({dmem_we, dmem_be, wb_valid, wb_write, wb_reg, addr_error, bus_error}), 32'd0);
    check("rst_acc.addr", dmem_addr, 32'd0);
    check("rst_acc.wdata", dmem_wdata, 32'd0);
    check("rst_acc.wb_data", wb_data, 32'd0);
    check("rst_acc.stall", 32'(stall), 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    @(negedge clock);
    dmem_ack = 1'b0;
    check("rst_acc.late_ack_wbv", 32'(wb_valid), 32'd0);
    @(negedge clock);
    check("rst_acc.late_ack_wbv2", 32'(wb_valid), 32'd0);
    check("rst_acc.late_ack_req", 32'(dmem_req), 32'd0);

    // Stage still works after the reset
    do_op("post_rst", 1, 0, 2, 0, 1, 5'd1, 32'h0000_0500, 32'h0, 32'hCAFE_0001, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
